// File: rtl/egress_frame_scheduler.sv
// Frame-granular round-robin egress scheduler with a fixed inter-frame gap.
// Define EGRESS_SCHED_STATS_EN to add the tx_frames_o / underruns_o counters.
module egress_frame_scheduler #(
    parameter int P_PORTS     = 4,
    parameter int P_IFG       = 12,
    parameter int P_CNT_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic [P_PORTS-1:0]   frame_push_i,
    input  logic [P_PORTS-1:0]   q_empty_i,
    input  logic [P_PORTS*9-1:0] q_data_i,
    output logic [P_PORTS-1:0]   rd_o,
    output logic [P_PORTS-1:0]   grant_o,
    output logic [7:0]           tx_data_o,
    output logic                 tx_ctrl_o,
    output logic                 busy_o,
    output logic                 underrun_o,
    output logic                 cnt_ovf_o
`ifdef EGRESS_SCHED_STATS_EN
    ,
    output logic [31:0]          tx_frames_o,
    output logic [31:0]          underruns_o
`endif
);

    localparam int IDX_W = (P_PORTS > 1) ? $clog2(P_PORTS) : 1;
    localparam int GAP_W = (P_IFG > 1) ? $clog2(P_IFG) : 1;
    localparam logic [P_CNT_WIDTH-1:0] CNT_MAX = '1;

    // state | meaning: S_IDLE arbitrate | S_SEND pop granted frame | S_GAP forced idle
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [P_PORTS-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0]       gidx_q, gidx_d;
    logic [IDX_W-1:0]       rr_q, rr_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic                   tx_ctrl_q, tx_ctrl_d;
    logic                   underrun_q, underrun_d;
    logic                   ovf_q, ovf_d;
    logic [P_CNT_WIDTH-1:0] cnt_q [P_PORTS];
    logic [P_CNT_WIDTH-1:0] cnt_d [P_PORTS];

    logic [P_PORTS-1:0]     pending;
    logic [P_PORTS-1:0]     grant_dec;
    logic                   found;
    logic [IDX_W-1:0]       sel_idx;
    logic [IDX_W:0]         arb_sum;
    logic [8:0]             cur_word;
    logic                   cur_empty;
    logic                   pop;
    logic                   pop_done;

    assign cur_word  = q_data_i[gidx_q*9 +: 9];
    assign cur_empty = q_empty_i[gidx_q];
    assign pop       = (state_q == S_SEND) && !cur_empty;
    assign pop_done  = pop && cur_word[0];

    always_comb begin
        for (int i = 0; i < P_PORTS; i++) begin
            pending[i] = (cnt_q[i] != '0);
        end
    end

    // Search starts at rr and wraps, so the first hit is the round-robin winner.
    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        arb_sum = '0;
        for (int k = 0; k < P_PORTS; k++) begin
            arb_sum = {1'b0, rr_q} + (IDX_W+1)'(k);
            if (arb_sum >= (IDX_W+1)'(P_PORTS)) begin
                arb_sum = arb_sum - (IDX_W+1)'(P_PORTS);
            end
            if (!found && pending[arb_sum[IDX_W-1:0]]) begin
                found   = 1'b1;
                sel_idx = arb_sum[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        gidx_d     = gidx_q;
        rr_d       = rr_q;
        gap_d      = gap_q;
        tx_data_d  = tx_data_q;
        tx_ctrl_d  = 1'b0;
        underrun_d = 1'b0;
        grant_dec  = '0;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d            = '0;
                    grant_d[sel_idx]   = 1'b1;
                    gidx_d             = sel_idx;
                    grant_dec[sel_idx] = 1'b1;
                    rr_d    = (sel_idx == IDX_W'(P_PORTS-1)) ? '0 : sel_idx + IDX_W'(1);
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (cur_empty) begin
                    underrun_d = 1'b1;
                end else begin
                    tx_data_d = cur_word[8:1];
                    tx_ctrl_d = 1'b1;
                    if (cur_word[0]) begin
                        grant_d = '0;
                        if (P_IFG > 0) begin
                            gap_d   = GAP_W'(P_IFG - 1);
                            state_d = S_GAP;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A push and a grant in the same cycle cancel; saturation only on a net increment.
    always_comb begin
        ovf_d = 1'b0;
        for (int i = 0; i < P_PORTS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (frame_push_i[i] && !grant_dec[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + P_CNT_WIDTH'(1);
                end
            end else if (grant_dec[i] && !frame_push_i[i]) begin
                cnt_d[i] = cnt_q[i] - P_CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            gidx_q     <= '0;
            rr_q       <= '0;
            gap_q      <= '0;
            tx_data_q  <= '0;
            tx_ctrl_q  <= 1'b0;
            underrun_q <= 1'b0;
            ovf_q      <= 1'b0;
            for (int i = 0; i < P_PORTS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            rr_q       <= rr_d;
            gap_q      <= gap_d;
            tx_data_q  <= tx_data_d;
            tx_ctrl_q  <= tx_ctrl_d;
            underrun_q <= underrun_d;
            ovf_q      <= ovf_d;
            for (int i = 0; i < P_PORTS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        rd_o = '0;
        if (pop) begin
            rd_o[gidx_q] = 1'b1;
        end
    end

    assign grant_o    = grant_q;
    assign tx_data_o  = tx_data_q;
    assign tx_ctrl_o  = tx_ctrl_q;
    assign busy_o     = (state_q != S_IDLE);
    assign underrun_o = underrun_q;
    assign cnt_ovf_o  = ovf_q;

`ifdef EGRESS_SCHED_STATS_EN
    logic [31:0] tx_frames_q, tx_frames_d;
    logic [31:0] underruns_q, underruns_d;

    assign tx_frames_d = pop_done ? tx_frames_q + 32'd1 : tx_frames_q;
    assign underruns_d = underrun_d ? underruns_q + 32'd1 : underruns_q;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            tx_frames_q <= '0;
            underruns_q <= '0;
        end else begin
            tx_frames_q <= tx_frames_d;
            underruns_q <= underruns_d;
        end
    end

    assign tx_frames_o = tx_frames_q;
    assign underruns_o = underruns_q;
`endif

endmodule

// File: tb/tb_egress_frame_scheduler.sv
// Directed bench for egress_frame_scheduler (4 ports, 12-cycle gap, 8-bit counters).
module tb_egress_frame_scheduler;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [3:0]  frame_push = '0;
    logic [3:0]  q_empty;
    logic [35:0] q_data;
    logic [3:0]  rd;
    logic [3:0]  grant;
    logic [7:0]  tx_data;
    logic        tx_ctrl;
    logic        busy;
    logic        underrun;
    logic        cnt_ovf;
`ifdef EGRESS_SCHED_STATS_EN
    logic [31:0] tx_frames;
    logic [31:0] underruns;
`endif

    int checks = 0;
    int errors = 0;

    egress_frame_scheduler #(.P_PORTS(4), .P_IFG(12), .P_CNT_WIDTH(8)) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .frame_push_i (frame_push),
        .q_empty_i    (q_empty),
        .q_data_i     (q_data),
        .rd_o         (rd),
        .grant_o      (grant),
        .tx_data_o    (tx_data),
        .tx_ctrl_o    (tx_ctrl),
        .busy_o       (busy),
        .underrun_o   (underrun),
        .cnt_ovf_o    (cnt_ovf)
`ifdef EGRESS_SCHED_STATS_EN
        ,
        .tx_frames_o  (tx_frames),
        .underruns_o  (underruns)
`endif
    );

    always #5 clk = ~clk;

    // FWFT queue models feeding the scheduler
    logic [8:0] qmem [4][64];
    int         wptr [4];
    int         rptr [4];
    logic [3:0] force_empty = '0;
    logic [3:0] flush = '0;

    always_comb begin
        q_empty = '0;
        q_data  = '0;
        for (int i = 0; i < 4; i++) begin
            q_empty[i]       = (rptr[i] == wptr[i]) || force_empty[i];
            q_data[i*9 +: 9] = qmem[i][rptr[i] % 64];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (flush[i]) rptr[i] <= wptr[i];
            else if (rd[i]) rptr[i] <= rptr[i] + 1;
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            wptr[i] = 0;
            rptr[i] = 0;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic put(input int p, input logic [7:0] b, input logic done);
        qmem[p][wptr[p] % 64] = {b, done};
        wptr[p] = wptr[p] + 1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        flush = 4'hF;
        step(2);
        rstn = 1'b1;
        flush = '0;
    endtask

    task automatic wait_tx(input string tag, input logic [7:0] exp, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!tx_ctrl && n < 200);
        chk({tag, "_seen"}, tx_ctrl, 1'b1);
        chk({tag, "_data"}, tx_data, exp);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 200) begin
            step();
            n++;
        end
        chk(tag, busy, 1'b0);
    endtask

    int n;
    int ovf_seen;

    initial begin
        // reset state
        step(2);
        chk("rst_grant", grant, 4'h0);
        chk("rst_rd", rd, 4'h0);
        chk("rst_tx_ctrl", tx_ctrl, 1'b0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_underrun", underrun, 1'b0);
        chk("rst_ovf", cnt_ovf, 1'b0);
        rstn = 1'b1;
        step();

        // single 3-byte frame on input 2
        put(2, 8'hAA, 1'b0); put(2, 8'hBB, 1'b0); put(2, 8'hCC, 1'b1);
        frame_push = 4'b0100;
        step();
        frame_push = '0;
        chk("f1_grant_n1", grant, 4'b0000);
        step();
        chk("f1_grant_n2", grant, 4'b0100);
        chk("f1_rd_n2", rd, 4'b0100);
        chk("f1_txc_n2", tx_ctrl, 1'b0);
        step();
        chk("f1_txc_b0", tx_ctrl, 1'b1);
        chk("f1_txd_b0", tx_data, 8'hAA);
        step();
        chk("f1_txc_b1", tx_ctrl, 1'b1);
        chk("f1_txd_b1", tx_data, 8'hBB);
        step();
        chk("f1_txc_b2", tx_ctrl, 1'b1);
        chk("f1_txd_b2", tx_data, 8'hCC);
        chk("f1_grant_clr", grant, 4'b0000);
        chk("f1_rd_gap", rd, 4'b0000);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("f1_gap_busy_%0d", i), busy, 1'b1);
            step();
            if (i < 11) chk($sformatf("f1_gap_txc_%0d", i), tx_ctrl, 1'b0);
        end
        chk("f1_idle_after_gap", busy, 1'b0);

        // all four push together, rr = 0 after reset
        do_reset();
        for (int i = 0; i < 4; i++) put(i, 8'h10 + 8'(i), 1'b1);
        frame_push = 4'b1111;
        step();
        frame_push = '0;
        wait_tx("rr_p0", 8'h10, n);
        wait_tx("rr_p1", 8'h11, n);
        chk("rr_b2b_spacing", n, 14);
        wait_tx("rr_p2", 8'h12, n);
        wait_tx("rr_p3", 8'h13, n);
        wait_idle("rr_idle_a");

        // one frame on input 0 moves rr to 1; then 1 beats 0
        put(0, 8'h20, 1'b1);
        frame_push = 4'b0001;
        step();
        frame_push = '0;
        wait_tx("rr1_p0", 8'h20, n);
        put(0, 8'h30, 1'b1);
        put(1, 8'h31, 1'b1);
        frame_push = 4'b0011;
        step();
        frame_push = '0;
        wait_tx("rr1_first_p1", 8'h31, n);
        wait_tx("rr1_then_p0", 8'h30, n);
        wait_idle("rr_idle_b");

        // input 3 frame sets rr to 0; during its gap: 3 frames on input 0, 1 on input 3
        put(3, 8'h40, 1'b1);
        frame_push = 4'b1000;
        step();
        frame_push = '0;
        wait_tx("mix_pre_p3", 8'h40, n);
        put(0, 8'h50, 1'b1); put(0, 8'h51, 1'b1); put(0, 8'h52, 1'b1);
        put(3, 8'h43, 1'b1);
        frame_push = 4'b1001;
        step();
        frame_push = 4'b0001;
        step();
        step();
        frame_push = '0;
        chk("mix_busy_gap", busy, 1'b1);
        chk("mix_cnt0_3", dut.cnt_q[0], 8'd3);
        chk("mix_cnt3_1", dut.cnt_q[3], 8'd1);
        wait_tx("mix_1st_p0", 8'h50, n);
        chk("mix_cnt0_2", dut.cnt_q[0], 8'd2);
        wait_tx("mix_2nd_p3", 8'h43, n);
        chk("mix_cnt3_0", dut.cnt_q[3], 8'd0);
        wait_tx("mix_3rd_p0", 8'h51, n);
        chk("mix_cnt0_1", dut.cnt_q[0], 8'd1);
        wait_tx("mix_4th_p0", 8'h52, n);
        chk("mix_cnt0_0", dut.cnt_q[0], 8'd0);
        wait_idle("mix_idle");

        // input 1 frame with a 2-cycle empty stall mid-frame
        put(1, 8'h61, 1'b0); put(1, 8'h62, 1'b0); put(1, 8'h63, 1'b0); put(1, 8'h64, 1'b1);
        frame_push = 4'b0010;
        step();
        frame_push = '0;
        wait_tx("ur_b0", 8'h61, n);
        force_empty[1] = 1'b1;
        #1;
        chk("ur_rd_stall", rd, 4'b0000);
        step();
        chk("ur_pulse1", underrun, 1'b1);
        chk("ur_txc_low1", tx_ctrl, 1'b0);
        step();
        chk("ur_pulse2", underrun, 1'b1);
        chk("ur_txc_low2", tx_ctrl, 1'b0);
        force_empty[1] = 1'b0;
        step();
        chk("ur_pulse_end", underrun, 1'b0);
        chk("ur_txc_b1", tx_ctrl, 1'b1);
        chk("ur_txd_b1", tx_data, 8'h62);
`ifdef EGRESS_SCHED_STATS_EN
        chk("ur_underruns", underruns, 32'd2);
`endif
        step();
        chk("ur_txd_b2", tx_data, 8'h63);
        step();
        chk("ur_txd_b3", tx_data, 8'h64);
        chk("ur_grant_clr", grant, 4'b0000);
`ifdef EGRESS_SCHED_STATS_EN
        chk("ur_tx_frames", tx_frames, 32'd13);
`endif

        // counter saturation: input 1 stalls in SEND, input 2 gets 256 pushes
        do_reset();
        frame_push = 4'b0010;
        step();
        frame_push = '0;
        step();
        chk("sat_busy", busy, 1'b1);
        chk("sat_grant", grant, 4'b0010);
        ovf_seen = 0;
        for (int i = 0; i < 256; i++) begin
            frame_push = 4'b0100;
            step();
            if (cnt_ovf) ovf_seen++;
        end
        frame_push = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (cnt_ovf) ovf_seen++;
        end
        chk("sat_ovf_count", ovf_seen, 1);
        chk("sat_cnt2", dut.cnt_q[2], 8'd255);
        chk("sat_ovf_low", cnt_ovf, 1'b0);
        chk("sat_underrun", underrun, 1'b1);

        // reset during byte 5 of an 8-byte frame
        do_reset();
        chk("mr_cnt2_clr", dut.cnt_q[2], 8'd0);
        chk("mr_busy_clr", busy, 1'b0);
        for (int i = 0; i < 8; i++) put(0, 8'h71 + 8'(i), (i == 7));
        frame_push = 4'b0001;
        step();
        frame_push = '0;
        wait_tx("mr_b0", 8'h71, n);
        step(3);
        chk("mr_txd_b3", tx_data, 8'h74);
        chk("mr_rd_b4", rd, 4'b0001);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        chk("mr_rd", rd, 4'b0000);
        chk("mr_tx_ctrl", tx_ctrl, 1'b0);
        chk("mr_busy", busy, 1'b0);
        chk("mr_grant", grant, 4'b0000);
        for (int i = 0; i < 4; i++) chk($sformatf("mr_cnt%0d", i), dut.cnt_q[i], 8'd0);
        step();
        chk("mr_stay_idle", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
